// File: rtl/icache_pkg.sv
// icache_pkg: shared state encoding, geometry helpers and memory constants for the L1 instruction cache
package icache_pkg;
  typedef enum logic [2:0] {INIT, IDLE, FILL, RESP, FLUSH} state_t;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;
  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction
  function automatic int offset_w(input int words);
    return $clog2(words);
  endfunction
  function automatic int tag_w(input int addr_w, input int sets, input int words);
    return addr_w - $clog2(sets) - $clog2(words) - 2;
  endfunction
endpackage

// File: rtl/icache_way.sv
// icache_way: tag, valid and data storage for one cache way with combinational read and one write port
module icache_way import icache_pkg::*; #(
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 8,
  parameter int TAG_W      = 23
) (
  input  logic                          mclk,
  input  logic [index_w(SETS)-1:0]      rd_index,
  input  logic [offset_w(LINE_WORDS)-1:0] rd_offset,
  output logic                          rd_valid,
  output logic [TAG_W-1:0]              rd_tag,
  output logic [31:0]                   rd_data,
  input  logic                          clr,
  input  logic                          data_we,
  input  logic                          tag_we,
  input  logic [index_w(SETS)-1:0]      wr_index,
  input  logic [offset_w(LINE_WORDS)-1:0] wr_offset,
  input  logic [31:0]                   wr_data,
  input  logic [TAG_W-1:0]              wr_tag
);
  logic             valid [SETS];
  logic [TAG_W-1:0] tags  [SETS];
  logic [31:0]      data  [SETS*LINE_WORDS];
  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = data[{rd_index, rd_offset}];
  // set-walk clear has priority; the tag write marks the line valid once the fill is complete
  always_ff @(posedge mclk)
    if (clr) valid[wr_index] <= 1'b0;
    else if (tag_we) begin
      valid[wr_index] <= 1'b1;
      tags[wr_index]  <= wr_tag;
    end
  // one fill beat per write
  always_ff @(posedge mclk)
    if (data_we) data[{wr_index, wr_offset}] <= wr_data;
endmodule

// File: rtl/icache_l1.sv
// icache_l1: parametrised read-only L1 instruction cache with optional 2-way LRU and fence.i flush
module icache_l1 import icache_pkg::*; #(
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 8,
  parameter int WAYS       = 1,
  parameter int ADDR_W     = 32
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [31:0]       fetch_instr,
  output logic              fetch_err,
  input  logic              flush,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_rw_req,
  output logic              mem_rw,
  output logic [1:0]        mem_size,
  input  logic [31:0]       mem_read_data,
  input  logic              mem_rec
);
  localparam int IW = index_w(SETS);
  localparam int OW = offset_w(LINE_WORDS);
  localparam int TW = tag_w(ADDR_W, SETS, LINE_WORDS);
  state_t          state, state_nx;
  logic [IW-1:0]   set_cnt, req_idx, wr_idx, pc_idx;
  logic [OW-1:0]   beat, req_off, pc_off;
  logic [TW-1:0]   req_tag, pc_tag;
  logic            victim_r, fill_done, flush_pend;
  logic            lru [SETS];
  logic [WAYS-1:0] way_valid;
  logic [TW-1:0]   way_tag [WAYS];
  logic [31:0]     way_data [WAYS];
  logic            hit, hit_way, victim, misaligned, accept;
  logic            clr, data_we, tag_we;
  logic [31:0]     hit_data;
  assign pc_idx     = fetch_pc[OW+2 +: IW];
  assign pc_off     = fetch_pc[2 +: OW];
  assign pc_tag     = fetch_pc[ADDR_W-1 -: TW];
  assign misaligned = |fetch_pc[1:0];
  assign accept     = state == IDLE && fetch_req && !flush;
  assign mem_rw     = 1'b0;
  assign mem_size   = MEM_SIZE_WORD;
  for (genvar g = 0; g < WAYS; g++) begin : g_way
    icache_way #(.SETS(SETS), .LINE_WORDS(LINE_WORDS), .TAG_W(TW)) u_way (
      .mclk      (mclk),
      .rd_index  (pc_idx),
      .rd_offset (pc_off),
      .rd_valid  (way_valid[g]),
      .rd_tag    (way_tag[g]),
      .rd_data   (way_data[g]),
      .clr       (clr),
      .data_we   (data_we && victim_r == 1'(g)),
      .tag_we    (tag_we && victim_r == 1'(g)),
      .wr_index  (wr_idx),
      .wr_offset (beat),
      .wr_data   (mem_read_data),
      .wr_tag    (req_tag)
    );
  end
  // tag compare across ways; victim is the first invalid way, otherwise the LRU way
  always_comb begin
    hit      = 1'b0;
    hit_way  = 1'b0;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++)
      if (way_valid[w] && way_tag[w] == pc_tag) begin
        hit      = 1'b1;
        hit_way  = 1'(w);
        hit_data = way_data[w];
      end
    victim = (WAYS == 2 && way_valid[0]) ? (way_valid[WAYS-1] ? lru[pc_idx] : 1'b1) : 1'b0;
  end
  // state register
  always_ff @(posedge mclk)
    state <= reset ? INIT : state_nx;
  // next-state logic; flush beats a simultaneous fetch in IDLE
  always_comb begin
    state_nx = state;
    case (state)
      INIT, FLUSH: state_nx = (set_cnt == IW'(SETS - 1)) ? IDLE : state;
      IDLE:        state_nx = flush ? FLUSH : !fetch_req ? IDLE : (misaligned || hit) ? RESP : FILL;
      FILL:        state_nx = fill_done ? RESP : FILL;
      RESP:        state_nx = (flush_pend || flush) ? FLUSH : IDLE;
      default:     state_nx = INIT;
    endcase
  end
  // state-decoded outputs and storage write strobes; the cycle after the last beat commits the tag
  always_comb begin
    fetch_ready = state == IDLE;
    fetch_valid = state == RESP;
    mem_rw_req  = state == FILL && !fill_done;
    clr         = state == INIT || state == FLUSH;
    data_we     = mem_rw_req && mem_rec;
    tag_we      = state == FILL && fill_done;
    wr_idx      = clr ? set_cnt : req_idx;
  end
  // request capture, fill sequencing, response word and flush bookkeeping
  always_ff @(posedge mclk)
    if (reset) begin
      set_cnt     <= '0;
      flush_pend  <= 1'b0;
      fetch_instr <= '0;
      fetch_err   <= 1'b0;
      mem_address <= '0;
      beat        <= '0;
      fill_done   <= 1'b0;
      req_idx     <= '0;
      req_off     <= '0;
      req_tag     <= '0;
      victim_r    <= 1'b0;
    end else begin
      set_cnt    <= clr ? set_cnt + 1'b1 : set_cnt;
      flush_pend <= !clr && (flush_pend || (flush && (state == FILL || state == RESP)));
      if (accept) begin
        fetch_instr <= misaligned ? '0 : hit_data;
        fetch_err   <= misaligned;
        req_idx     <= pc_idx;
        req_off     <= pc_off;
        req_tag     <= pc_tag;
        victim_r    <= victim;
        beat        <= '0;
        fill_done   <= 1'b0;
        if (!misaligned && !hit) mem_address <= {fetch_pc[ADDR_W-1:OW+2], {(OW+2){1'b0}}};
      end
      if (data_we) begin
        mem_address <= mem_address + ADDR_W'(4);
        beat        <= beat + 1'b1;
        fill_done   <= beat == OW'(LINE_WORDS - 1);
        if (beat == req_off) fetch_instr <= mem_read_data;
      end
    end
  // LRU bit names the way to evict next: the one not just hit or filled
  always_ff @(posedge mclk)
    if (clr) lru[set_cnt] <= 1'b0;
    else if (accept && !misaligned && hit) lru[pc_idx] <= ~hit_way;
    else if (tag_we) lru[req_idx] <= ~victim_r;
endmodule
